ram_arbiter: RTL and testbench

- Two-requester access controller for the 4096 x 4-bit program/data RAM of the nibble processor.
- Arbitrates between the instruction-fetch unit (read-only) and the data/execute unit (read/write).
- Sequences one RAM access at a time and drives chip-select, read/write, address and write data.
- Returns read nibbles to the requester that was granted.
- Sits between the fetch/execute logic and the RAM. The top level connects ram_addr[11:8] to the RAM operand field and ram_addr[7:0] to the program-byte field. The top level also builds the tri-state data bus from ram_wdata and ram_data_oe.

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/rr_pick2.sv | 21 ++
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the nibble-processor RAM arbiter: FSM states, requester IDs
// and default bus widths.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone request wins, a tie goes to the
// requester that was not served last.
module rr_pick2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       win
);

    always_comb begin
        valid = |req;
        win   = REQ_FETCH;
        if (req[REQ_FETCH] && req[REQ_DATA])
            win = ~last;
        else if (req[REQ_DATA])
            win = REQ_DATA;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port access controller for the 4096 x 4 program/data RAM, shared
// between the instruction-fetch unit (read-only) and the data unit.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants the round-robin winner
//   ACCESS | ram_cs held for WAIT_CYCLES cycles, read nibble captured at end
//   DONE   | done pulse to the winner, RAM bus returned to zero
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t     state;
    req_id_t    last;
    req_id_t    winner;
    logic [3:0] wait_cnt;
    logic       pick_valid;
    logic       pick_win;

    rr_pick2 u_pick (
        .req   ({data_req, fetch_req}),
        .last  (last),
        .valid (pick_valid),
        .win   (pick_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= REQ_DATA;
            winner      <= REQ_FETCH;
            wait_cnt    <= 4'd0;
            fetch_gnt   <= 1'b0;
            fetch_rdata <= '0;
            fetch_done  <= 1'b0;
            data_gnt    <= 1'b0;
            data_rdata  <= '0;
            data_done   <= 1'b0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_data_oe <= 1'b0;
        end else begin
            fetch_gnt  <= 1'b0;
            data_gnt   <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner   <= req_id_t'(pick_win);
                        last     <= req_id_t'(pick_win);
                        wait_cnt <= 4'(WAIT_CYCLES - 1);
                        ram_cs   <= 1'b1;
                        state    <= ACCESS;
                        if (pick_win == REQ_DATA) begin
                            data_gnt    <= 1'b1;
                            ram_addr    <= data_addr;
                            ram_we      <= data_we;
                            ram_wdata   <= data_we ? data_wdata : '0;
                            ram_data_oe <= data_we;
                        end else begin
                            fetch_gnt   <= 1'b1;
                            ram_addr    <= fetch_addr;
                            ram_we      <= 1'b0;
                            ram_wdata   <= '0;
                            ram_data_oe <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Last chip-select cycle: read data is valid on ram_rdata now.
                        if (winner == REQ_DATA) begin
                            data_done <= 1'b1;
                            if (!ram_we)
                                data_rdata <= ram_rdata;
                        end else begin
                            fetch_done  <= 1'b1;
                            fetch_rdata <= ram_rdata;
                        end
                        ram_cs      <= 1'b0;
                        ram_we      <= 1'b0;
                        ram_addr    <= '0;
                        ram_wdata   <= '0;
                        ram_data_oe <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a WAIT_CYCLES=1 instance checked through a
// completion scoreboard, and a WAIT_CYCLES=3 instance for timing and mid-access reset.
module tb_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       who;
        logic [3:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    // instance A: WAIT_CYCLES = 1
    logic        a_reset, a_fetch_req, a_data_req, a_data_we;
    logic [11:0] a_fetch_addr, a_data_addr;
    logic [3:0]  a_data_wdata;
    logic        a_fetch_gnt, a_fetch_done, a_data_gnt, a_data_done;
    logic [3:0]  a_fetch_rdata, a_data_rdata;
    logic        a_ram_cs, a_ram_we, a_ram_data_oe;
    logic [11:0] a_ram_addr;
    logic [3:0]  a_ram_wdata, a_ram_rdata;
    logic [3:0]  mem_a [4096];

    // instance B: WAIT_CYCLES = 3
    logic        b_reset, b_fetch_req, b_data_req, b_data_we;
    logic [11:0] b_fetch_addr, b_data_addr;
    logic [3:0]  b_data_wdata;
    logic        b_fetch_gnt, b_fetch_done, b_data_gnt, b_data_done;
    logic [3:0]  b_fetch_rdata, b_data_rdata;
    logic        b_ram_cs, b_ram_we, b_ram_data_oe;
    logic [11:0] b_ram_addr;
    logic [3:0]  b_ram_wdata, b_ram_rdata;
    logic [3:0]  mem_b [4096];

    ram_arbiter #(.ADDR_W(12), .DATA_W(4), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .reset(a_reset),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr), .fetch_gnt(a_fetch_gnt),
        .fetch_rdata(a_fetch_rdata), .fetch_done(a_fetch_done),
        .data_req(a_data_req), .data_we(a_data_we), .data_addr(a_data_addr),
        .data_wdata(a_data_wdata), .data_gnt(a_data_gnt), .data_rdata(a_data_rdata),
        .data_done(a_data_done), .ram_cs(a_ram_cs), .ram_we(a_ram_we),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_data_oe(a_ram_data_oe),
        .ram_rdata(a_ram_rdata)
    );

    ram_arbiter #(.ADDR_W(12), .DATA_W(4), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .reset(b_reset),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_gnt(b_fetch_gnt),
        .fetch_rdata(b_fetch_rdata), .fetch_done(b_fetch_done),
        .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr),
        .data_wdata(b_data_wdata), .data_gnt(b_data_gnt), .data_rdata(b_data_rdata),
        .data_done(b_data_done), .ram_cs(b_ram_cs), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_data_oe(b_ram_data_oe),
        .ram_rdata(b_ram_rdata)
    );

    assign a_ram_rdata = mem_a[a_ram_addr];
    assign b_ram_rdata = mem_b[b_ram_addr];

    // RAM models: preloaded at time 0, written on a rising edge while cs & we.
    always @(posedge clk) begin
        if (a_ram_cs && a_ram_we) mem_a[a_ram_addr] = a_ram_wdata;
        if (b_ram_cs && b_ram_we) mem_b[b_ram_addr] = b_ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Completion monitor for instance A: each done pops the next expected result.
    always @(negedge clk) begin
        if (a_fetch_done || a_data_done) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed done with empty queue, expected none");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_who", 32'(a_data_done), 32'(e.who));
                chk("done_data", 32'(a_data_done ? a_data_rdata : a_fetch_rdata), 32'(e.data));
            end
        end
    end

    initial begin
        bit got;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 4'h0;
            mem_b[i] = 4'h0;
        end
        mem_a[12'h0A5] = 4'h7;
        mem_a[12'h100] = 4'h3;
        mem_b[12'h100] = 4'h3;
        mem_b[12'h200] = 4'h5;
        mem_b[12'h010] = 4'h9;

        a_reset = 1'b1; a_fetch_req = 1'b1; a_data_req = 1'b1; a_data_we = 1'b0;
        a_fetch_addr = 12'h0A5; a_data_addr = 12'h100; a_data_wdata = 4'h0;
        b_reset = 1'b1; b_fetch_req = 1'b0; b_data_req = 1'b0; b_data_we = 1'b0;
        b_fetch_addr = 12'h000; b_data_addr = 12'h000; b_data_wdata = 4'h0;

        // Reset held 3 cycles with both requests high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs_zero",
                32'({a_fetch_gnt, a_fetch_rdata, a_fetch_done, a_data_gnt, a_data_rdata,
                     a_data_done, a_ram_cs, a_ram_we, a_ram_addr, a_ram_wdata, a_ram_data_oe}),
                32'h0);
        end

        // Both requests held: fetch, data, fetch, data, grants 3 cycles apart.
        exp_q.push_back('{1'b0, 4'h7});
        exp_q.push_back('{1'b1, 4'h3});
        exp_q.push_back('{1'b0, 4'h7});
        exp_q.push_back('{1'b1, 4'h3});
        a_reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("rr_fetch_gnt", 32'(a_fetch_gnt), 32'((c % 3 == 1) && (((c - 1) / 3) % 2 == 0)));
            chk("rr_data_gnt", 32'(a_data_gnt), 32'((c % 3 == 1) && (((c - 1) / 3) % 2 == 1)));
            chk("rr_ram_cs", 32'(a_ram_cs), 32'(c % 3 == 1));
            if (c == 1) begin
                chk("fetch_ram_addr", 32'(a_ram_addr), 32'h0A5);
                chk("fetch_ram_we", 32'(a_ram_we), 32'h0);
            end
            if (c == 10) begin
                a_fetch_req = 1'b0;
                a_data_req  = 1'b0;
            end
        end

        // Data write 0xFFF <- C; data_rdata must keep the last read value.
        a_data_req = 1'b1; a_data_we = 1'b1; a_data_addr = 12'hFFF; a_data_wdata = 4'hC;
        exp_q.push_back('{1'b1, 4'h3});
        tick();
        chk("wr_data_gnt", 32'(a_data_gnt), 32'h1);
        chk("wr_ram_we", 32'(a_ram_we), 32'h1);
        chk("wr_ram_oe", 32'(a_ram_data_oe), 32'h1);
        chk("wr_ram_addr", 32'(a_ram_addr), 32'hFFF);
        chk("wr_ram_wdata", 32'(a_ram_wdata), 32'hC);
        a_data_req = 1'b0;
        tick();
        chk("wr_done_ram_we", 32'(a_ram_we), 32'h0);
        chk("wr_done_ram_oe", 32'(a_ram_data_oe), 32'h0);
        chk("wr_done_pulse", 32'(a_data_done), 32'h1);
        tick();

        // Fetch read back of 0xFFF.
        a_fetch_req = 1'b1; a_fetch_addr = 12'hFFF;
        exp_q.push_back('{1'b0, 4'hC});
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            tick();
            if (a_fetch_gnt) a_fetch_req = 1'b0;
        end
        a_fetch_req = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        // Instance B: WAIT_CYCLES=3 data read of 0x100.
        b_reset = 1'b0;
        tick();
        b_data_req = 1'b1; b_data_we = 1'b0; b_data_addr = 12'h100;
        tick();
        chk("w3_data_gnt", 32'(b_data_gnt), 32'h1);
        chk("w3_cs_c1", 32'(b_ram_cs), 32'h1);
        b_data_req = 1'b0;
        tick();
        chk("w3_cs_c2", 32'(b_ram_cs), 32'h1);
        tick();
        chk("w3_cs_c3", 32'(b_ram_cs), 32'h1);
        chk("w3_no_early_done", 32'(b_data_done), 32'h0);
        tick();
        chk("w3_cs_c4", 32'(b_ram_cs), 32'h0);
        chk("w3_done_c4", 32'(b_data_done), 32'h1);
        chk("w3_rdata", 32'(b_data_rdata), 32'h3);
        tick();
        chk("w3_done_single", 32'(b_data_done), 32'h0);

        // Reset in the 2nd ACCESS cycle of a read of 0x200.
        b_data_req = 1'b1; b_data_addr = 12'h200;
        tick();
        chk("rst_mid_gnt", 32'(b_data_gnt), 32'h1);
        b_data_req = 1'b0;
        tick();
        chk("rst_mid_cs_before", 32'(b_ram_cs), 32'h1);
        b_reset = 1'b1;
        tick();
        chk("rst_mid_cs_after", 32'(b_ram_cs), 32'h0);
        chk("rst_mid_no_done", 32'(b_data_done), 32'h0);
        b_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_idle_quiet", 32'({b_data_done, b_data_gnt, b_ram_cs}), 32'h0);
        end

        // A fresh data read of 0x010 completes normally.
        b_data_req = 1'b1; b_data_addr = 12'h010;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (b_data_gnt) b_data_req = 1'b0;
            if (b_data_done) begin
                got = 1'b1;
                chk("post_rst_rdata", 32'(b_data_rdata), 32'h9);
            end
        end
        b_data_req = 1'b0;
        chk("post_rst_done_seen", 32'(got), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
